// File: rtl/dnn_loader_pkg.sv
// Shared types and frame-layout constants for the DNN frame loader.
package dnn_loader_pkg;

  typedef enum logic [1:0] {
    RST_HOLD,
    LOAD,
    FIRE,
    WAIT
  } state_t;

  localparam int N_X            = 4;
  localparam int N_W            = 24;
  localparam int FRAME_WORDS    = 28;
  localparam int HDR_RELOAD_BIT = 0;

endpackage

// File: rtl/dnn_frame_loader.sv
// Serial-to-parallel loader: streams x0..x3 and 24 weights into held registers, launches the DNN.
// Optional build macro DNN_LOADER_WEIGHT_PERSIST_EN: per-frame header word selects weight reload.
module dnn_frame_loader
  import dnn_loader_pkg::*;
#(
  parameter int input_width  = 5,
  parameter int weight_width = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [input_width-1:0]  s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [input_width-1:0]  x0,
  output logic [input_width-1:0]  x1,
  output logic [input_width-1:0]  x2,
  output logic [input_width-1:0]  x3,
  output logic [weight_width-1:0] w04,
  output logic [weight_width-1:0] w05,
  output logic [weight_width-1:0] w06,
  output logic [weight_width-1:0] w07,
  output logic [weight_width-1:0] w14,
  output logic [weight_width-1:0] w15,
  output logic [weight_width-1:0] w16,
  output logic [weight_width-1:0] w17,
  output logic [weight_width-1:0] w24,
  output logic [weight_width-1:0] w25,
  output logic [weight_width-1:0] w26,
  output logic [weight_width-1:0] w27,
  output logic [weight_width-1:0] w34,
  output logic [weight_width-1:0] w35,
  output logic [weight_width-1:0] w36,
  output logic [weight_width-1:0] w37,
  output logic [weight_width-1:0] w48,
  output logic [weight_width-1:0] w58,
  output logic [weight_width-1:0] w49,
  output logic [weight_width-1:0] w59,
  output logic [weight_width-1:0] w68,
  output logic [weight_width-1:0] w69,
  output logic [weight_width-1:0] w78,
  output logic [weight_width-1:0] w79,
  output logic                    in_ready,
  input  logic                    out0_ready,
  input  logic                    out1_ready,
  output logic                    busy
);

  state_t                  state;
  logic [4:0]              cnt;
  logic                    hold_done;
  logic                    seen0;
  logic                    seen1;
  logic                    accept;
  logic                    is_hdr;
  logic                    last_word;
  logic                    both_seen;
  logic [4:0]              widx;
  logic [input_width-1:0]  x_q [N_X];
  logic [weight_width-1:0] w_q [N_W];

`ifdef DNN_LOADER_WEIGHT_PERSIST_EN
  logic hdr_seen;
  logic reload;
`endif

  assign accept    = s_valid && s_ready;
  assign both_seen = (seen0 || out0_ready) && (seen1 || out1_ready);
  assign widx      = cnt - 5'(N_X);

  always_comb begin
    is_hdr    = 1'b0;
    last_word = (cnt == 5'(FRAME_WORDS - 1));
`ifdef DNN_LOADER_WEIGHT_PERSIST_EN
    // Counter indexes data words only; the header is tracked separately.
    is_hdr    = !hdr_seen;
    last_word = hdr_seen && (cnt == (reload ? 5'(FRAME_WORDS - 1) : 5'(N_X - 1)));
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RST_HOLD;
      cnt       <= '0;
      hold_done <= 1'b0;
      seen0     <= 1'b0;
      seen1     <= 1'b0;
      s_ready   <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
`ifdef DNN_LOADER_WEIGHT_PERSIST_EN
      hdr_seen  <= 1'b0;
      reload    <= 1'b0;
`endif
    end else begin
      case (state)
        RST_HOLD: begin
          // One full idle cycle after the first post-reset edge before arming.
          if (!hold_done) begin
            hold_done <= 1'b1;
          end else begin
            state   <= LOAD;
            s_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            if (is_hdr) begin
`ifdef DNN_LOADER_WEIGHT_PERSIST_EN
              hdr_seen <= 1'b1;
              reload   <= s_data[HDR_RELOAD_BIT];
`endif
            end else if (last_word) begin
              state    <= FIRE;
              s_ready  <= 1'b0;
              in_ready <= 1'b1;
              busy     <= 1'b1;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        FIRE: begin
          in_ready <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          seen0 <= seen0 || out0_ready;
          seen1 <= seen1 || out1_ready;
          if (both_seen) begin
            state   <= LOAD;
            s_ready <= 1'b1;
            busy    <= 1'b0;
            seen0   <= 1'b0;
            seen1   <= 1'b0;
            cnt     <= '0;
`ifdef DNN_LOADER_WEIGHT_PERSIST_EN
            hdr_seen <= 1'b0;
`endif
          end
        end
        default: begin
          state   <= RST_HOLD;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_X; i++) x_q[i] <= '0;
      for (int unsigned i = 0; i < N_W; i++) w_q[i] <= '0;
    end else if (accept && !is_hdr) begin
      if (cnt < 5'(N_X)) x_q[cnt[1:0]] <= s_data;
      else               w_q[widx]     <= s_data[weight_width-1:0];
    end
  end

  assign x0  = x_q[0];
  assign x1  = x_q[1];
  assign x2  = x_q[2];
  assign x3  = x_q[3];

  assign w04 = w_q[0];
  assign w05 = w_q[1];
  assign w06 = w_q[2];
  assign w07 = w_q[3];
  assign w14 = w_q[4];
  assign w15 = w_q[5];
  assign w16 = w_q[6];
  assign w17 = w_q[7];
  assign w24 = w_q[8];
  assign w25 = w_q[9];
  assign w26 = w_q[10];
  assign w27 = w_q[11];
  assign w34 = w_q[12];
  assign w35 = w_q[13];
  assign w36 = w_q[14];
  assign w37 = w_q[15];
  assign w48 = w_q[16];
  assign w58 = w_q[17];
  assign w49 = w_q[18];
  assign w59 = w_q[19];
  assign w68 = w_q[20];
  assign w69 = w_q[21];
  assign w78 = w_q[22];
  assign w79 = w_q[23];

endmodule

// File: tb/tb_dnn_frame_loader.sv
// Randomized frame-level bench for dnn_frame_loader against a frame/register reference model.
module tb_dnn_frame_loader;

  localparam int IW = 7;
  localparam int WW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [IW-1:0] x0, x1, x2, x3;
  logic [WW-1:0] w04, w05, w06, w07, w14, w15, w16, w17, w24, w25, w26, w27;
  logic [WW-1:0] w34, w35, w36, w37, w48, w58, w49, w59, w68, w69, w78, w79;
  logic          in_ready;
  logic          out0_ready;
  logic          out1_ready;
  logic          busy;

  logic [IW-1:0] xv [4];
  logic [WW-1:0] wv [24];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          exp_x [4];
  int          exp_w [24];

  always #5 clk = ~clk;

  dnn_frame_loader #(.input_width(IW), .weight_width(WW)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .w04(w04), .w05(w05), .w06(w06), .w07(w07), .w14(w14), .w15(w15), .w16(w16), .w17(w17),
    .w24(w24), .w25(w25), .w26(w26), .w27(w27), .w34(w34), .w35(w35), .w36(w36), .w37(w37),
    .w48(w48), .w58(w58), .w49(w49), .w59(w59), .w68(w68), .w69(w69), .w78(w78), .w79(w79),
    .in_ready(in_ready), .out0_ready(out0_ready), .out1_ready(out1_ready), .busy(busy)
  );

  assign xv[0] = x0;  assign xv[1] = x1;  assign xv[2] = x2;  assign xv[3] = x3;
  assign wv[0]  = w04; assign wv[1]  = w05; assign wv[2]  = w06; assign wv[3]  = w07;
  assign wv[4]  = w14; assign wv[5]  = w15; assign wv[6]  = w16; assign wv[7]  = w17;
  assign wv[8]  = w24; assign wv[9]  = w25; assign wv[10] = w26; assign wv[11] = w27;
  assign wv[12] = w34; assign wv[13] = w35; assign wv[14] = w36; assign wv[15] = w37;
  assign wv[16] = w48; assign wv[17] = w58; assign wv[18] = w49; assign wv[19] = w59;
  assign wv[20] = w68; assign wv[21] = w69; assign wv[22] = w78; assign wv[23] = w79;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++)  check($sformatf("%s_x%0d", tag, i), 32'(xv[i]), 32'(exp_x[i]));
    for (int i = 0; i < 24; i++) check($sformatf("%s_w%0d", tag, i), 32'(wv[i]), 32'(exp_w[i]));
  endtask

  task automatic check_ctl(input string tag, input logic sr, input logic ir, input logic b);
    check({tag, "_s_ready"},  32'(s_ready),  32'(sr));
    check({tag, "_in_ready"}, 32'(in_ready), 32'(ir));
    check({tag, "_busy"},     32'(busy),     32'(b));
  endtask

  // Reset is applied right after a rising edge; its effect is expected immediately.
  task automatic do_reset(input string tag);
    rst = 1'b1; s_valid = 1'b0; s_data = '0; out0_ready = 1'b0; out1_ready = 1'b0;
    for (int i = 0; i < 4; i++)  exp_x[i] = 0;
    for (int i = 0; i < 24; i++) exp_w[i] = 0;
    #1;
    check_regs(tag);
    check_ctl(tag, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check({tag, "_hold_s_ready"}, 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    check({tag, "_arm_s_ready"}, 32'(s_ready), 32'd1);
  endtask

  task automatic send_word(input int w, input bit gapped, output bit ok);
    logic rdy;
    ok = 1'b0;
    if (gapped) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = IW'(w);
    out0_ready = 1'($urandom_range(0, 1));
    out1_ready = 1'($urandom_range(0, 1));
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk) rdy = s_ready;
      @(posedge clk); #1;
      if (rdy === 1'b1) ok = 1'b1;
    end
    s_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_frame(input bit reload_in, input bit gapped, input bit basic);
    int  q[$];
    int  xs[4];
    int  ws[24];
    bit  ok;
    bit  reload;
    reload = reload_in;
`ifdef DNN_LOADER_WEIGHT_PERSIST_EN
    q.push_back(int'(($urandom_range(0, (1 << IW) - 1) & ~32'd1) | 32'(reload)));
`else
    reload = 1'b1;
`endif
    for (int i = 0; i < 4; i++) begin
      xs[i] = basic ? i + 1 : int'($urandom_range(0, (1 << IW) - 1));
      q.push_back(xs[i]);
    end
    if (reload) begin
      for (int i = 0; i < 24; i++) begin
        ws[i] = basic ? i + 5 : int'($urandom_range(0, (1 << IW) - 1));
        q.push_back(ws[i]);
      end
    end
    for (int k = 0; k < q.size(); k++) begin
      send_word(q[k], gapped, ok);
      if (!ok) return;
      if (k < q.size() - 1) check("no_early_launch", 32'(in_ready), 32'd0);
    end
    for (int i = 0; i < 4; i++) exp_x[i] = xs[i];
    if (reload) for (int i = 0; i < 24; i++) exp_w[i] = ws[i] & ((1 << WW) - 1);
    check_ctl("fire", 1'b0, 1'b1, 1'b1);
    check_regs("fire");
    out0_ready = 1'($urandom_range(0, 1));
    out1_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    check_ctl("wait_entry", 1'b0, 1'b0, 1'b1);
  endtask

  // Stream is held valid with all-ones data throughout WAIT; nothing may be accepted.
  task automatic finish_wait(input int d0, input int d1);
    int m;
    m = (d0 > d1) ? d0 : d1;
    s_valid = 1'b1;
    s_data  = '1;
    for (int c = 0; c <= m; c++) begin
      out0_ready = (c == d0);
      out1_ready = (c == d1);
      @(posedge clk); #1;
      if (c < m) begin
        check_ctl("wait", 1'b0, 1'b0, 1'b1);
        if (c == m / 2) check_regs("wait_mid");
      end
    end
    check_regs("wait_end");
    check_ctl("rearm", 1'b1, 1'b0, 1'b0);
    s_valid = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit ok;
    rst = 1'b1;
    do_reset("reset");

    run_frame(1'b1, 1'b0, 1'b1);
    finish_wait(3, 7);

    run_frame(1'b1, 1'b1, 1'b1);
    finish_wait(0, 0);

    run_frame(1'b1, 1'b0, 1'b0);
    finish_wait(6, 2);

    for (int f = 0; f < 8; f++) begin
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      finish_wait(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
    end

`ifdef DNN_LOADER_WEIGHT_PERSIST_EN
    send_word(1, 1'b0, ok);
`endif
    for (int k = 0; k < 10; k++) send_word(int'($urandom_range(0, (1 << IW) - 1)), 1'b0, ok);
    do_reset("mid_reset");
    run_frame(1'b1, 1'b0, 1'b0);
    finish_wait(1, 4);
    run_frame(1'b0, 1'b1, 1'b0);
    finish_wait(2, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
